// File: rtl/vram_responder.sv
// VRAM responder: zero-latency video read port plus a host port whose accesses are
// confined to a fixed window of the 16-cycle fetch period.
module vram_responder #(
   parameter int MEM_BYTES      = 11008,
   parameter int HOST_WIN_START = 0,
   parameter int HOST_WIN_END   = 5
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] vid_addr,
   output logic [7:0]  vid_data,
   input  logic        host_req,
   input  logic        host_we,
   input  logic [15:0] host_addr,
   input  logic [7:0]  host_wdata,
   output logic        host_ack,
   output logic [7:0]  host_rdata,
   output logic        host_err
);

   localparam int          AW         = $clog2(MEM_BYTES);
   localparam logic [15:0] ADDR_LIMIT = 16'(MEM_BYTES);
   localparam logic [3:0]  WIN_LO     = 4'(HOST_WIN_START);
   localparam logic [3:0]  WIN_SPAN   = 4'(HOST_WIN_END - HOST_WIN_START);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_ACK} state_t;

   state_t      state, state_next;
   logic [3:0]  slot, slot_next;
   logic        win_next;
   logic        we_q;
   logic [15:0] addr_q;
   logic [7:0]  wdata_q;
   logic        in_range;
   logic [7:0]  mem [MEM_BYTES];

   assign slot_next = slot + 4'd1;
   // Modular distance from the window start avoids a constant compare when START is 0.
   assign win_next  = (4'(slot_next - WIN_LO)) <= WIN_SPAN;
   assign in_range  = addr_q < ADDR_LIMIT;

   // NOTE: sequential state uses non-blocking assignments so every register samples
   // pre-edge values regardless of process ordering.
   always_ff @(posedge clk) begin
      if (reset) begin
         slot  <= 4'd0;
         state <= S_IDLE;
      end else begin
         slot  <= slot_next;
         state <= state_next;
      end
   end

   always_comb begin
      // NOTE: default first so no path through the case leaves state_next unassigned
      // (which would infer a latch).
      state_next = state;
      unique case (state)
         S_IDLE:   if (host_req) state_next = win_next ? S_ACCESS : S_WAIT;
         S_WAIT:   if (win_next) state_next = S_ACCESS;
         S_ACCESS: state_next = S_ACK;
         S_ACK:    state_next = S_IDLE;
         default:  state_next = S_IDLE;
      endcase
   end

   // Request fields are only consumed after acceptance, so they need no reset value.
   always_ff @(posedge clk) begin
      if (state == S_IDLE && host_req) begin
         we_q    <= host_we;
         addr_q  <= host_addr;
         wdata_q <= host_wdata;
      end
   end

   // NOTE: the memory array is deliberately not reset; only control and output
   // registers are.
   always_ff @(posedge clk) begin
      if (state == S_ACCESS && we_q && in_range)
         mem[addr_q[AW-1:0]] <= wdata_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         host_ack   <= 1'b0;
         host_err   <= 1'b0;
         host_rdata <= 8'h00;
      end else begin
         host_ack <= (state == S_ACCESS);
         host_err <= (state == S_ACCESS) && !in_range;
         if (state == S_ACCESS) begin
            if (!in_range)
               host_rdata <= 8'h00;
            else if (!we_q)
               host_rdata <= mem[addr_q[AW-1:0]];
         end
      end
   end

   assign vid_data = (vid_addr < ADDR_LIMIT) ? mem[vid_addr[AW-1:0]] : 8'h00;

endmodule

// File: tb/tb_vram_responder.sv
// Directed bench for vram_responder: slot-window latency, range errors, reset abort
// and zero-latency video reads against a small reference memory.
module tb_vram_responder;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] vid_addr;
   logic [7:0]  vid_data;
   logic        host_req;
   logic        host_we;
   logic [15:0] host_addr;
   logic [7:0]  host_wdata;
   logic        host_ack;
   logic [7:0]  host_rdata;
   logic        host_err;

   int checks = 0;
   int errors = 0;

   logic [3:0] tb_slot;
   logic [7:0] ref_mem [int];

   vram_responder dut (
      .clk        (clk),
      .reset      (reset),
      .vid_addr   (vid_addr),
      .vid_data   (vid_data),
      .host_req   (host_req),
      .host_we    (host_we),
      .host_addr  (host_addr),
      .host_wdata (host_wdata),
      .host_ack   (host_ack),
      .host_rdata (host_rdata),
      .host_err   (host_err)
   );

   always #5 clk = ~clk;

   // Independent slot model: cleared by reset, free-running mod 16.
   always @(posedge clk) begin
      if (reset) tb_slot <= 4'd0;
      else       tb_slot <= tb_slot + 4'd1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_slot(input logic [3:0] s);
      @(negedge clk);
      for (int i = 0; i < 32 && tb_slot != s; i++) @(negedge clk);
   endtask

   // Raises a request at the current negedge, returns at the negedge of the ack cycle.
   task automatic do_req(input logic we, input logic [15:0] addr, input logic [7:0] wd,
                         output logic [3:0] aslot, output logic [7:0] rd,
                         output logic er);
      logic got = 1'b0;
      aslot = 4'd0; rd = 8'h00; er = 1'b0;
      host_req = 1'b1; host_we = we; host_addr = addr; host_wdata = wd;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (host_ack) begin
            got = 1'b1; aslot = tb_slot; rd = host_rdata; er = host_err;
            break;
         end
      end
      host_req = 1'b0;
      check("ack_seen", 32'(got), 32'd1);
      if (got && we && addr < 16'd11008) ref_mem[int'(addr)] = wd;
   endtask

   logic [3:0]  a_slot;
   logic [7:0]  a_rd;
   logic        a_er;
   logic [15:0] sweep [6];

   initial begin
      reset = 1'b1; vid_addr = 16'h0000; host_req = 1'b0; host_we = 1'b0;
      host_addr = 16'h0000; host_wdata = 8'h00;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      check("rst_ack", 32'(host_ack), 32'd0);
      check("rst_err", 32'(host_err), 32'd0);
      check("rst_rdata", 32'(host_rdata), 32'd0);

      // Write at slot 0: ACCESS at slot 1, ack at slot 2, visible on video immediately.
      vid_addr = 16'h1800;
      do_req(1'b1, 16'h1800, 8'hA5, a_slot, a_rd, a_er);
      check("t1_ack_slot", 32'(a_slot), 32'd2);
      check("t1_err", 32'(a_er), 32'd0);
      check("t1_vid", 32'(vid_data), 32'hA5);

      // Read raised at slot 7 waits for the next window: ACCESS slot 0, ack slot 1.
      wait_slot(4'd7);
      do_req(1'b0, 16'h1800, 8'h00, a_slot, a_rd, a_er);
      check("t2_ack_slot", 32'(a_slot), 32'd1);
      check("t2_rdata", 32'(a_rd), 32'hA5);
      check("t2_err", 32'(a_er), 32'd0);

      // Last valid byte, then the first out-of-range address.
      wait_slot(4'd3);
      do_req(1'b1, 16'h2AFF, 8'h3C, a_slot, a_rd, a_er);
      check("t3_last_err", 32'(a_er), 32'd0);
      vid_addr = 16'h2AFF;
      #1 check("t3_last_vid", 32'(vid_data), 32'h3C);
      wait_slot(4'd10);
      do_req(1'b1, 16'h2B00, 8'h77, a_slot, a_rd, a_er);
      check("t3_oor_err", 32'(a_er), 32'd1);
      check("t3_oor_rdata", 32'(a_rd), 32'd0);
      check("t3_oor_slot", 32'(a_slot), 32'd1);
      check("t3_neighbour_vid", 32'(vid_data), 32'h3C);
      @(negedge clk);
      check("t3_err_pulse", 32'(host_err), 32'd0);
      check("t3_ack_pulse", 32'(host_ack), 32'd0);
      vid_addr = 16'h2B00;
      #1 check("t3_oor_vid", 32'(vid_data), 32'd0);
      wait_slot(4'd2);
      do_req(1'b0, 16'h2AFF, 8'h00, a_slot, a_rd, a_er);
      check("t3_last_read", 32'(a_rd), 32'h3C);

      // Window edge: next slot 5 is inside, next slot 6 is not.
      wait_slot(4'd4);
      do_req(1'b1, 16'h2700, 8'h42, a_slot, a_rd, a_er);
      check("t4_edge_in", 32'(a_slot), 32'd6);
      wait_slot(4'd5);
      do_req(1'b0, 16'h2700, 8'h00, a_slot, a_rd, a_er);
      check("t4_edge_out", 32'(a_slot), 32'd1);
      check("t4_rdata", 32'(a_rd), 32'h42);

      // Reset during WAIT aborts the write to the palette byte.
      wait_slot(4'd2);
      do_req(1'b1, 16'h2AC0, 8'h11, a_slot, a_rd, a_er);
      wait_slot(4'd8);
      host_req = 1'b1; host_we = 1'b1; host_addr = 16'h2AC0; host_wdata = 8'h99;
      repeat (2) @(negedge clk);
      reset = 1'b1; host_req = 1'b0;
      @(negedge clk);
      check("t5_ack_in_reset", 32'(host_ack), 32'd0);
      reset = 1'b0;
      vid_addr = 16'h2AC0;
      #1;
      check("t5_ack", 32'(host_ack), 32'd0);
      check("t5_err", 32'(host_err), 32'd0);
      check("t5_rdata", 32'(host_rdata), 32'd0);
      check("t5_mem", 32'(vid_data), 32'h11);
      do_req(1'b0, 16'h2AC0, 8'h00, a_slot, a_rd, a_er);
      check("t5_slot_realigned", 32'(a_slot), 32'd2);
      check("t5_read", 32'(a_rd), 32'h11);

      // Tile bytes, then a video sweep concurrent with a host write elsewhere.
      for (int i = 0; i < 4; i++) begin
         wait_slot(4'd0);
         do_req(1'b1, 16'(i), 8'(8'h30 + i), a_slot, a_rd, a_er);
      end
      sweep[0] = 16'h1800; sweep[1] = 16'h2700; sweep[2] = 16'h0000;
      sweep[3] = 16'h0001; sweep[4] = 16'h0002; sweep[5] = 16'h0003;
      wait_slot(4'd9);
      fork
         do_req(1'b1, 16'h0100, 8'h5A, a_slot, a_rd, a_er);
         for (int i = 0; i < 24; i++) begin
            vid_addr = sweep[i % 6];
            #1 check("t6_sweep", 32'(vid_data), 32'(ref_mem[int'(sweep[i % 6])]));
            @(negedge clk);
         end
      join
      vid_addr = 16'h0100;
      #1 check("t6_host_write", 32'(vid_data), 32'h5A);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
